// File: rtl/tx_fifo_if.sv
// ---------------------------------------------------------------------------
// tx_fifo_if
// Bundle of the host-write and transmit-read signals of the transmit FIFO.
//   master : the APB host side and the transmit shift logic. It drives
//            psel, pwrite, pwdata and tx_rd, and observes the FIFO outputs.
//   slave  : the FIFO itself. It receives the requests and drives txdata,
//            tx_valid, tx_empty, tx_full, ssptxintr and tx_ovr.
// ---------------------------------------------------------------------------
interface tx_fifo_if #(
   parameter int WIDTH = 8
);
   logic             psel;
   logic             pwrite;
   logic [WIDTH-1:0] pwdata;
   logic             tx_rd;
   logic [WIDTH-1:0] txdata;
   logic             tx_valid;
   logic             tx_empty;
   logic             tx_full;
   logic             ssptxintr;
   logic             tx_ovr;

   modport master (
      output psel, pwrite, pwdata, tx_rd,
      input  txdata, tx_valid, tx_empty, tx_full, ssptxintr, tx_ovr
   );

   modport slave (
      input  psel, pwrite, pwdata, tx_rd,
      output txdata, tx_valid, tx_empty, tx_full, ssptxintr, tx_ovr
   );
endinterface

// File: rtl/tx_fifo.sv
// ---------------------------------------------------------------------------
// tx_fifo
// Transmit-side FIFO of the synchronous serial port. The APB host pushes
// bytes in, and the transmit shift logic pops them out one word per cycle.
// Ports:
//   pclk    : port clock. All state changes on its rising edge.
//   clear_b : asynchronous active-low clear of all state.
//   bus     : tx_fifo_if slave modport.
//             Inputs : psel, pwrite, pwdata, tx_rd.
//             Outputs: txdata, tx_valid, tx_empty, tx_full, ssptxintr,
//                      tx_ovr.
// ---------------------------------------------------------------------------
module tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic       pclk,
   input  logic       clear_b,
   tx_fifo_if.slave   bus
);
   localparam logic [AW:0]   FullCount = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CountOne  = (AW+1)'(1);
   localparam logic [AW-1:0] PtrOne    = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] txdata_q, txdata_d;
   logic             valid_q, valid_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic             ovr_q, ovr_d;
   logic             rdOk, wrReq, wrOk;

   // Every accept/reject decision looks only at the registered count.
   // A write into a full FIFO still goes through when a pop frees a slot
   // in the same cycle. A read of an empty FIFO is never bypassed from a
   // write in the same cycle, so that write becomes readable one cycle later.
   // The flags are computed from the post-update count, so they are
   // registered and line up with the new contents.
   always_comb begin
      rdOk     = bus.tx_rd & (count_q != '0);
      wrReq    = bus.psel & bus.pwrite;
      wrOk     = wrReq & ((count_q != FullCount) | rdOk);

      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      count_d  = count_q;
      txdata_d = txdata_q;
      valid_d  = rdOk;
      ovr_d    = ovr_q | (wrReq & ~wrOk);

      if (rdOk) begin
         txdata_d = mem_q[rptr_q];
         rptr_d   = rptr_q + PtrOne;
      end
      if (wrOk) begin
         wptr_d = wptr_q + PtrOne;
      end

      case ({wrOk, rdOk})
         2'b10:   count_d = count_q + CountOne;
         2'b01:   count_d = count_q - CountOne;
         default: count_d = count_q;
      endcase

      empty_d  = (count_d == '0);
      full_d   = (count_d == FullCount);
   end

   // State register. A low clear_b wipes the memory and any pending
   // tx_valid pulse at once, without waiting for pclk, so a reset during a
   // transfer drops all queued data.
   always_ff @(posedge pclk or negedge clear_b) begin
      if (!clear_b) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         txdata_q <= '0;
         valid_q  <= 1'b0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         if (wrOk) begin
            mem_q[wptr_q] <= bus.pwdata;
         end
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         txdata_q <= txdata_d;
         valid_q  <= valid_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         ovr_q    <= ovr_d;
      end
   end

   // The interrupt asks the host to stop writing, so it mirrors the full flag.
   assign bus.txdata    = txdata_q;
   assign bus.tx_valid  = valid_q;
   assign bus.tx_empty  = empty_q;
   assign bus.tx_full   = full_q;
   assign bus.ssptxintr = full_q;
   assign bus.tx_ovr    = ovr_q;
endmodule

// File: doc/tx_fifo.md
Name: tx_fifo

Overview:
Transmit-side FIFO for the synchronous serial port. It is the counterpart of the receive FIFO: the APB host writes bytes in, and the transmit shift logic pulls them out.
- 4-entry x 8-bit circular buffer.
- Raises ssptxintr when full so the host stops writing.
- Reports empty to the transmit logic and flags dropped host writes.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 4, number of FIFO entries (power of two, >= 2)
AW, 2, pointer width, log2(DEPTH)

Ports:
pclk  input  1  port clock; all state updates on rising edge
clear_b  input  1  asynchronous active-low reset/clear
psel  input  1  peripheral select from APB
pwrite  input  1  host write strobe; write when psel=1 and pwrite=1
pwdata  input  WIDTH  host write data
tx_rd  input  1  read request from transmit logic (one word per cycle high)
txdata  output  WIDTH  registered word delivered to transmit logic
tx_valid  output  1  one-cycle pulse: txdata holds a newly popped word
tx_empty  output  1  FIFO holds 0 words
tx_full  output  1  FIFO holds DEPTH words
ssptxintr  output  1  transmit interrupt, high while FIFO full
tx_ovr  output  1  sticky overflow: a host write was dropped

Behaviour:
- Reset: clear_b low asynchronously clears state, independent of psel and pclk, and holds it while low.
  - Memory, wptr, rptr, count and txdata go to 0.
  - tx_valid=0, tx_full=0, ssptxintr=0, tx_ovr=0, tx_empty=1.
- Storage and pointers:
  - Circular memory of DEPTH x WIDTH; wptr and rptr are AW bits and wrap naturally (3 -> 0).
  - count is AW+1 bits, range 0..DEPTH, and never under- or overflows.
- Decisions: all of the following use registered state at the clock edge.
  - rd_ok = tx_rd & (count != 0)
  - wr_req = psel & pwrite
  - wr_ok = wr_req & ((count != DEPTH) | rd_ok)
- Read (rd_ok):
  - txdata <= mem[rptr]; rptr <= rptr+1.
  - tx_valid=1 on the following cycle only; latency is 1 cycle from tx_rd to data.
  - tx_rd while empty is ignored: tx_valid=0 and txdata holds its last value.
- Write (wr_ok): mem[wptr] <= pwdata; wptr <= wptr+1.
- Count update: +1 for a write only, -1 for a read only, unchanged for both or neither.
- Simultaneous events:
  - Full with a read and a write in the same cycle: both are accepted, count stays DEPTH.
  - Empty with a read and a write in the same cycle: the write is accepted and the read is rejected; there is no bypass. Data becomes readable on the next cycle.
- Overflow: wr_req with count==DEPTH and no rd_ok drops pwdata and sets tx_ovr. tx_ovr stays set until clear_b.
- psel=1 with pwrite=0 has no effect on this block; host reads belong to the receive FIFO.
- Flags are registered and derived from the post-update count, so they are valid the cycle after the causing edge:
  - tx_empty = (count==0)
  - tx_full = (count==DEPTH)
  - ssptxintr = tx_full
- No state other than via clear_b changes while psel=0 and tx_rd=0.
- Reset mid-transfer: a pending tx_valid pulse is cancelled and all queued data is discarded.

Test Plan:
- Reset then idle:
  - clear_b low for 2 cycles, then high -> tx_empty=1, tx_full=0, ssptxintr=0, tx_ovr=0, txdata=8'h00.
  - Hold tx_rd=1 on the empty FIFO -> tx_valid never pulses.
- Fill and drain:
  - Write 8'hA1, 8'hB2, 8'hC3, 8'hD4 -> tx_full=1 and ssptxintr=1 after the 4th edge.
  - tx_rd for 4 cycles -> txdata A1, B2, C3, D4 each with a tx_valid pulse; tx_empty=1 afterwards.
- Overflow:
  - Fill with 8'h11..8'h44, then write 8'h55 -> tx_ovr=1, count stays 4.
  - Drain -> 11, 22, 33, 44; 8'h55 never appears; tx_ovr remains 1.
- Simultaneous access:
  - With the FIFO full, assert write 8'h66 and tx_rd together -> pop returns the oldest word, tx_full stays 1, tx_ovr stays 0.
  - With the FIFO empty, write 8'h77 and tx_rd together -> no tx_valid; next-cycle tx_rd returns 8'h77.
- Wrap-around: 10 interleaved write/read pairs with data 8'h01..8'h0A -> output order 01..0A, pointers wrap cleanly, count returns to 0.
- Asynchronous reset mid-operation:
  - Put 3 words in, then drop clear_b between clock edges -> outputs reset immediately without a pclk edge.
  - After release, tx_empty=1 and tx_rd returns no data.
